cons: RTL and testbench

- Consumer end of the val/data streaming interface driven by the producer block.
- Samples `data` on every clock where `val` is high and groups consecutive valid cycles into bursts.
- When a burst closes, emits a one-cycle summary record: sum, length, maximum, and a length-violation flag.
- Keeps a running count of completed bursts; used as the checking sink in handshake-signalling benches.

---
 rtl/cons.sv | 111 +++++++++++
 tb/tb_cons.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cons.sv
// Consumer sink for the val/data stream: groups consecutive valid cycles into
// bursts and emits a one-cycle summary record (sum, length, max, error) per burst.
module cons #(
  parameter int DW      = 8,
  parameter int SW      = 12,
  parameter int LW      = 4,
  parameter int MIN_LEN = 3,
  parameter int MAX_LEN = 5
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          val,
  input  logic [DW-1:0] data,
  output logic          out_val,
  output logic [SW-1:0] out_sum,
  output logic [LW-1:0] out_len,
  output logic [DW-1:0] out_max,
  output logic          out_err,
  output logic [15:0]   burst_cnt
);

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic [SW-1:0] sum;
    logic [LW-1:0] len;
    logic [DW-1:0] mx;
  } acc_t;

  state_t        state, state_nxt;
  acc_t          acc;
  logic          open_burst, add_smp, close;
  logic [SW:0]   sum_ext;
  logic [SW-1:0] sum_add;
  logic [LW-1:0] len_add;
  logic [DW-1:0] max_add;
  logic          len_bad;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    open_burst = 1'b0;
    add_smp    = 1'b0;
    close      = 1'b0;
    case (state)
      IDLE: begin
        if (val) begin
          state_nxt  = BURST;
          open_burst = 1'b1;
        end
      end
      BURST: begin
        if (val) begin
          add_smp = 1'b1;
        end else begin
          state_nxt = IDLE;
          close     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One extra bit catches the carry so the sum pins at all-ones instead of wrapping.
  assign sum_ext = {1'b0, acc.sum} + (SW+1)'(data);
  assign sum_add = sum_ext[SW] ? {SW{1'b1}} : sum_ext[SW-1:0];
  assign len_add = (&acc.len) ? acc.len : acc.len + LW'(1);
  assign max_add = (data > acc.mx) ? data : acc.mx;

  // A pinned length is all-ones, which is always above MAX_LEN, so it flags as an error.
  assign len_bad = (acc.len < LW'(MIN_LEN)) || (acc.len > LW'(MAX_LEN));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc <= '0;
    end else if (open_burst) begin
      acc.sum <= SW'(data);
      acc.len <= LW'(1);
      acc.mx  <= data;
    end else if (add_smp) begin
      acc.sum <= sum_add;
      acc.len <= len_add;
      acc.mx  <= max_add;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_val   <= 1'b0;
      out_sum   <= '0;
      out_len   <= '0;
      out_max   <= '0;
      out_err   <= 1'b0;
      burst_cnt <= '0;
    end else begin
      out_val <= close;
      if (close) begin
        out_sum   <= acc.sum;
        out_len   <= acc.len;
        out_max   <= acc.mx;
        out_err   <= len_bad;
        burst_cnt <= burst_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cons.sv
// Scoreboard bench for cons: stimulus pushes expected records, a negedge monitor
// pops and compares each out_val pulse, including the cycle it arrives on.
module tb_cons;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        val = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        out_val;
  logic [11:0] out_sum;
  logic [3:0]  out_len;
  logic [7:0]  out_max;
  logic        out_err;
  logic [15:0] burst_cnt;

  cons #(.DW(8), .SW(12), .LW(4), .MIN_LEN(3), .MAX_LEN(5)) dut (
    .clk(clk), .rst_b(rst_b), .val(val), .data(data),
    .out_val(out_val), .out_sum(out_sum), .out_len(out_len),
    .out_max(out_max), .out_err(out_err), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] sum;
    logic [3:0]  len;
    logic [7:0]  mx;
    logic        err;
    logic [15:0] cnt;
    int          cyc;
  } rec_t;

  rec_t        sb[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_tot = 0;
  logic [15:0] exp_cnt = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every out_val pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    rec_t r;
    if (rst_b && out_val) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_out_val: got out_val=1 expected no record (cycle %0d)", cyc);
      end else begin
        r = sb.pop_front();
        chk("rec_cycle", cyc, r.cyc);
        chk("out_sum", 32'(out_sum), 32'(r.sum));
        chk("out_len", 32'(out_len), 32'(r.len));
        chk("out_max", 32'(out_max), 32'(r.mx));
        chk("out_err", 32'(out_err), 32'(r.err));
        chk("burst_cnt", 32'(burst_cnt), 32'(r.cnt));
      end
    end
  end

  task automatic smp(input logic [7:0] d);
    val  = 1'b1;
    data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      val  = 1'b0;
      data = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
  endtask

  // Drops val for one cycle (the close sample); the record is due one edge later.
  task automatic close_burst(input logic [11:0] s, input logic [3:0] l,
                             input logic [7:0] m, input logic e);
    rec_t r;
    exp_cnt = exp_cnt + 16'd1;
    r.sum = s; r.len = l; r.mx = m; r.err = e; r.cnt = exp_cnt; r.cyc = cyc + 1;
    sb.push_back(r);
    idle(1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_val"}, 32'(out_val), 0);
    chk({tag, "_out_sum"}, 32'(out_sum), 0);
    chk({tag, "_out_len"}, 32'(out_len), 0);
    chk({tag, "_out_max"}, 32'(out_max), 0);
    chk({tag, "_out_err"}, 32'(out_err), 0);
    chk({tag, "_burst_cnt"}, 32'(burst_cnt), 0);
  endtask

  initial begin
    int          blen;
    logic [11:0] s;
    logic [7:0]  m;
    logic [7:0]  d;

    #2 chk_zero("reset");
    #10 rst_b = 1'b1;
    @(posedge clk); #1;

    // Idle: the monitor flags any stray pulse.
    idle(10);
    chk_zero("idle");

    smp(2); smp(5); smp(1); smp(4);
    close_burst(12'd12, 4'd4, 8'd5, 1'b0);
    idle(2);

    smp(3); smp(3);
    close_burst(12'd6, 4'd2, 8'd3, 1'b1);
    idle(2);

    for (int i = 0; i < 6; i++) smp(1);
    close_burst(12'd6, 4'd6, 8'd1, 1'b1);
    idle(2);

    // Back-to-back bursts with a one-cycle gap: records land 4 cycles apart.
    smp(0); smp(0); smp(0);
    close_burst(12'd0, 4'd3, 8'd0, 1'b0);
    smp(5); smp(5); smp(5);
    close_burst(12'd15, 4'd3, 8'd5, 1'b0);
    idle(2);

    for (int i = 0; i < 20; i++) smp(8'd255);
    close_burst(12'd4095, 4'd15, 8'd255, 1'b1);
    idle(3);

    // Async reset mid-burst: partial burst dropped, outputs clear at once.
    smp(1);
    val = 1'b1; data = 8'd2;
    #3 rst_b = 1'b0;
    val = 1'b0;
    #1 chk_zero("midreset");
    #1 rst_b = 1'b1;
    exp_cnt = 16'd0;
    @(posedge clk); #1;
    idle(2);
    smp(1); smp(2); smp(3);
    close_burst(12'd6, 4'd3, 8'd3, 1'b0);
    idle(3);

    // Fresh reset so the long run counts from zero.
    #2 rst_b = 1'b0;
    exp_cnt = 16'd0;
    #2 rst_b = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 1000; b++) begin
      blen = $urandom_range(3, 5);
      s = 12'd0;
      m = 8'd0;
      for (int k = 0; k < blen; k++) begin
        d = 8'($urandom_range(0, 5));
        s = s + 12'(d);
        if (d > m) m = d;
        smp(d);
      end
      close_burst(s, 4'(blen), m, 1'b0);
      idle($urandom_range(1, 4) - 1);
    end
    idle(5);
    chk("final_burst_cnt", 32'(burst_cnt), 32'd1000);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
